proj_topk_reader: RTL and testbench



---
 rtl/proj_topk_reader.sv | 160 ++++++++++++++++
 tb/tb_proj_topk_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/proj_topk_reader.sv
// ---------------------------------------------------------------------------
// proj_topk_reader
//   Read-out stage behind proj_sorter. A capture pulse snapshots the sorter's
//   parallel smallest-index vector together with its fill count. The block
//   then streams the indices, smallest signature first, one per beat over a
//   valid/ready interface. The sorter can be refilled while the snapshot
//   drains.
//
// Ports
//   in_clk            clock, rising edge
//   in_rst            asynchronous active-high reset
//   in_smallest_idx   sorter result vector, entry 0 = smallest signature
//   in_fill_count     valid entries in in_smallest_idx (clamped to INDICES_COUNT)
//   in_capture        one-cycle snapshot request (honoured only while idle)
//   in_ready          downstream accepts the current beat
//   out_valid         beat valid
//   out_index         index carried by the beat
//   out_rank          0-based position of the beat in sorted order
//   out_last          final beat of the snapshot
//   out_busy          snapshot held, so captures are refused
//   out_done          one-cycle pulse after the last beat (or after an empty capture)
//   out_overrun       sticky, set when a capture was refused; cleared by reset
// ---------------------------------------------------------------------------
package proj_pkg;
   localparam int HASHER_EXTENDER_INDICES_COUNT = 8;
endpackage

module proj_topk_reader #(
   parameter int INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
   parameter int INDEX_W       = 8,
   parameter int CNT_W         = $clog2(INDICES_COUNT + 1)
) (
   input  logic                                  in_clk,
   input  logic                                  in_rst,
   input  logic [INDICES_COUNT-1:0][INDEX_W-1:0] in_smallest_idx,
   input  logic [CNT_W-1:0]                      in_fill_count,
   input  logic                                  in_capture,
   input  logic                                  in_ready,
   output logic                                  out_valid,
   output logic [INDEX_W-1:0]                    out_index,
   output logic [CNT_W-1:0]                      out_rank,
   output logic                                  out_last,
   output logic                                  out_busy,
   output logic                                  out_done,
   output logic                                  out_overrun
);

   // Width of a select into the snapshot buffer.
   localparam int SEL_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                                state_q;
   logic [INDICES_COUNT-1:0][INDEX_W-1:0] buf_q;
   logic [CNT_W-1:0]                      cnt_q;
   logic [CNT_W-1:0]                      ptr_q;
   logic                                  valid_q;
   logic [INDEX_W-1:0]                    index_q;
   logic [CNT_W-1:0]                      rank_q;
   logic                                  last_q;
   logic                                  done_q;
   logic                                  overrun_q;

   logic [CNT_W-1:0]                      cap_cnt_d;
   logic [CNT_W-1:0]                      ptr_inc_d;
   logic [SEL_W-1:0]                      nxt_sel_d;
   logic                                  nxt_last_d;

   always_comb begin
      cap_cnt_d  = (in_fill_count > CNT_W'(INDICES_COUNT)) ? CNT_W'(INDICES_COUNT)
                                                           : in_fill_count;
      ptr_inc_d  = ptr_q + CNT_W'(1);
      // ptr_inc_d is only used while ptr_q < cnt_q-1, so it stays inside the buffer.
      nxt_sel_d  = ptr_inc_d[SEL_W-1:0];
      nxt_last_d = (ptr_inc_d == (cnt_q - CNT_W'(1)));
   end

   // Beat outputs are registered and preloaded one edge ahead, so nothing
   // on the output side depends combinationally on in_ready or in_capture.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         rank_q    <= '0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (in_capture) begin
                  buf_q <= in_smallest_idx;
                  cnt_q <= cap_cnt_d;
                  ptr_q <= '0;
                  if (cap_cnt_d != '0) begin
                     state_q <= SEND;
                     valid_q <= 1'b1;
                     index_q <= in_smallest_idx[0];
                     rank_q  <= '0;
                     last_q  <= (cap_cnt_d == CNT_W'(1));
                  end else begin
                     // Empty snapshot: no beats, just the completion pulse.
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end

            SEND: begin
               if (in_capture) overrun_q <= 1'b1;
               if (in_ready) begin
                  if (last_q) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     index_q <= '0;
                     rank_q  <= '0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     ptr_q   <= ptr_inc_d;
                     index_q <= buf_q[nxt_sel_d];
                     rank_q  <= ptr_inc_d;
                     last_q  <= nxt_last_d;
                  end
               end
            end

            DONE: begin
               if (in_capture) overrun_q <= 1'b1;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid   = valid_q;
   assign out_index   = index_q;
   assign out_rank    = rank_q;
   assign out_last    = last_q;
   assign out_busy    = (state_q != IDLE);
   assign out_done    = done_q;
   assign out_overrun = overrun_q;

endmodule

// File: tb/tb_proj_topk_reader.sv
// ---------------------------------------------------------------------------
// tb_proj_topk_reader
//   Directed bench for proj_topk_reader with INDICES_COUNT=4, INDEX_W=8.
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   the same point, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_proj_topk_reader;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0][W-1:0] sidx = '0;
   logic [CW-1:0]     fill = '0;
   logic              cap  = 1'b0;
   logic              rdy  = 1'b0;

   logic              out_valid;
   logic [W-1:0]      out_index;
   logic [CW-1:0]     out_rank;
   logic              out_last;
   logic              out_busy;
   logic              out_done;
   logic              out_overrun;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] orig [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] alt  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
   logic       pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   proj_topk_reader #(
      .INDICES_COUNT(N),
      .INDEX_W      (W),
      .CNT_W        (CW)
   ) dut (
      .in_clk         (clk),
      .in_rst         (rst),
      .in_smallest_idx(sidx),
      .in_fill_count  (fill),
      .in_capture     (cap),
      .in_ready       (rdy),
      .out_valid      (out_valid),
      .out_index      (out_index),
      .out_rank       (out_rank),
      .out_last       (out_last),
      .out_busy       (out_busy),
      .out_done       (out_done),
      .out_overrun    (out_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
      sidx[0] = a; sidx[1] = b; sidx[2] = c; sidx[3] = d;
   endtask

   task automatic beat(input string tag, input logic [7:0] idx, input int rank,
                       input logic last);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".index"}, 32'(out_index), 32'(idx));
      chk({tag, ".rank"},  32'(out_rank),  32'(rank));
      chk({tag, ".last"},  32'(out_last),  32'(last));
      chk({tag, ".busy"},  32'(out_busy),  32'd1);
      chk({tag, ".done"},  32'(out_done),  32'd0);
   endtask

   // Done-cycle check followed by the return to idle.
   task automatic finish_snap(input string tag);
      chk({tag, ".done"},  32'(out_done),  32'd1);
      chk({tag, ".dvld"},  32'(out_valid), 32'd0);
      chk({tag, ".dbusy"}, 32'(out_busy),  32'd1);
      step();
      chk({tag, ".idone"}, 32'(out_done),  32'd0);
      chk({tag, ".ibusy"}, 32'(out_busy),  32'd0);
   endtask

   task automatic capture(input logic [CW-1:0] f);
      fill = f;
      cap  = 1'b1;
      step();
      cap  = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      chk("rst.valid",   32'(out_valid),   32'd0);
      chk("rst.index",   32'(out_index),   32'd0);
      chk("rst.rank",    32'(out_rank),    32'd0);
      chk("rst.last",    32'(out_last),    32'd0);
      chk("rst.busy",    32'(out_busy),    32'd0);
      chk("rst.done",    32'(out_done),    32'd0);
      chk("rst.overrun", 32'(out_overrun), 32'd0);
      rst = 1'b0;
      step();
      chk("idle.valid", 32'(out_valid), 32'd0);

      // 1: full snapshot, ready held high
      load(8'h11, 8'h22, 8'h33, 8'h44);
      rdy = 1'b1;
      capture(3'd4);
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("t1.b%0d", i), orig[i], i, i == 3);
         step();
      end
      finish_snap("t1");

      // 2: same snapshot with ready toggling
      rdy = 1'b0;
      capture(3'd4);
      begin
         int p  = 0;
         int hs = 0;
         for (int i = 0; i < 7; i++) begin
            rdy = pat[i];
            beat($sformatf("t2.c%0d", i), orig[p], p, p == 3);
            step();
            if (pat[i]) begin p++; hs++; end
         end
         chk("t2.handshakes", 32'(hs), 32'd4);
      end
      rdy = 1'b1;
      finish_snap("t2");

      // 3a: fill 2
      capture(3'd2);
      beat("t3a.b0", 8'h11, 0, 1'b0);
      step();
      beat("t3a.b1", 8'h22, 1, 1'b1);
      step();
      finish_snap("t3a");

      // 3b: fill 0 -> no beats, done one cycle after capture
      capture(3'd0);
      finish_snap("t3b");

      // 3c: fill 7 clamps to 4
      capture(3'd7);
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("t3c.b%0d", i), orig[i], i, i == 3);
         step();
      end
      finish_snap("t3c");

      // 4: refused captures during SEND and on the final handshake
      chk("t4.ovr0", 32'(out_overrun), 32'd0);
      capture(3'd4);
      load(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      cap = 1'b1;
      beat("t4.b0", 8'h11, 0, 1'b0);
      step();
      cap = 1'b0;
      chk("t4.ovr1", 32'(out_overrun), 32'd1);
      beat("t4.b1", 8'h22, 1, 1'b0);
      step();
      beat("t4.b2", 8'h33, 2, 1'b0);
      step();
      beat("t4.b3", 8'h44, 3, 1'b1);
      cap = 1'b1;
      step();
      cap = 1'b0;
      chk("t4.ovr2", 32'(out_overrun), 32'd1);
      finish_snap("t4");
      capture(3'd4);
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("t4n.b%0d", i), alt[i], i, i == 3);
         step();
      end
      finish_snap("t4n");
      chk("t4.ovr3", 32'(out_overrun), 32'd1);

      // 5: reset mid-stream
      load(8'h11, 8'h22, 8'h33, 8'h44);
      capture(3'd4);
      step();
      step();
      beat("t5.b2", 8'h33, 2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t5.valid",   32'(out_valid),   32'd0);
      chk("t5.index",   32'(out_index),   32'd0);
      chk("t5.rank",    32'(out_rank),    32'd0);
      chk("t5.last",    32'(out_last),    32'd0);
      chk("t5.busy",    32'(out_busy),    32'd0);
      chk("t5.done",    32'(out_done),    32'd0);
      chk("t5.overrun", 32'(out_overrun), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("t5.nodone", 32'(out_done),  32'd0);
      chk("t5.novld",  32'(out_valid), 32'd0);
      capture(3'd4);
      for (int i = 0; i < 4; i++) begin
         beat($sformatf("t5r.b%0d", i), orig[i], i, i == 3);
         step();
      end
      finish_snap("t5r");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
